// File: rtl/rv32v_lane_mem_sequencer.sv
// Serializes the two vector memory lanes onto the single scalar data-memory port.
// Define RV32V_MEM_TIMEOUT_EN to enable the per-element wait timeout and the err pulse.
module rv32v_lane_mem_sequencer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        load,
  input  logic        store,
  input  logic        lane_en0,
  input  logic        lane_en1,
  input  logic [31:0] aluresult0,
  input  logic [31:0] aluresult1,
  input  logic [31:0] storedata0,
  input  logic [31:0] storedata1,
  input  logic [1:0]  eew,
  output logic        dmem_ren,
  output logic        dmem_wen,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byte_en,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic [31:0] loaddata0,
  output logic [31:0] loaddata1,
  output logic        stall,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, LANE0, LANE1, DONE} state_t;

  state_t      state;
  logic        st_p0;
  logic        en1_p0;
  logic [31:0] addr0_p0;
  logic [31:0] addr1_p0;
  logic [31:0] sd0_p0;
  logic [31:0] sd1_p0;
  logic [1:0]  eew_p0;

  logic        in_lane;
  logic [31:0] cur_addr;
  logic [31:0] cur_sd;
  logic [31:0] rd_ext;
  logic        lane_to;

  function automatic logic [3:0] byte_en_f(input logic [1:0] ew, input logic [1:0] lo);
    case (ew)
      2'd0:    byte_en_f = 4'b0001 << lo;
      2'd1:    byte_en_f = 4'b0011 << {lo[1], 1'b0};
      default: byte_en_f = 4'b1111;
    endcase
  endfunction

  // Bit offset of the element inside the 32-bit word; 32-bit (and eew=3) is never shifted.
  function automatic logic [4:0] shamt_f(input logic [1:0] ew, input logic [1:0] lo);
    case (ew)
      2'd0:    shamt_f = {lo, 3'b000};
      2'd1:    shamt_f = {lo[1], 4'b0000};
      default: shamt_f = 5'd0;
    endcase
  endfunction

  function automatic logic [31:0] wdata_f(input logic [1:0] ew, input logic [1:0] lo,
                                          input logic [31:0] data);
    wdata_f = data << shamt_f(ew, lo);
  endfunction

  function automatic logic [31:0] extract_f(input logic [1:0] ew, input logic [1:0] lo,
                                            input logic [31:0] rdata);
    logic [31:0] tmp;
    tmp = rdata >> shamt_f(ew, lo);
    case (ew)
      2'd0:    extract_f = {24'd0, tmp[7:0]};
      2'd1:    extract_f = {16'd0, tmp[15:0]};
      default: extract_f = tmp;
    endcase
  endfunction

  // Memory-side decode: depends only on state and latched fields, so reset clears it at once.
  always_comb begin
    in_lane      = (state == LANE0) || (state == LANE1);
    cur_addr     = (state == LANE1) ? addr1_p0 : addr0_p0;
    cur_sd       = (state == LANE1) ? sd1_p0 : sd0_p0;
    dmem_ren     = in_lane && !st_p0;
    dmem_wen     = in_lane && st_p0;
    dmem_addr    = in_lane ? {cur_addr[31:2], 2'b00} : 32'd0;
    dmem_byte_en = in_lane ? byte_en_f(eew_p0, cur_addr[1:0]) : 4'd0;
    dmem_wdata   = (in_lane && st_p0) ? wdata_f(eew_p0, cur_addr[1:0], cur_sd) : 32'd0;
    rd_ext       = extract_f(eew_p0, cur_addr[1:0], dmem_rdata);
    stall        = in_lane || ((state == IDLE) && (load || store));
    done         = (state == DONE);
  end

`ifdef RV32V_MEM_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] wait_cnt;
  logic       err_p0;

  assign lane_to = (wait_cnt == WAIT_LAST);
  assign err     = err_p0 && (state == DONE);

  // Counter restarts whenever a lane is entered (from IDLE or after the previous lane completes).
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wait_cnt <= 8'd0;
      err_p0   <= 1'b0;
    end else begin
      if (!in_lane || dmem_ready || lane_to) begin
        wait_cnt <= 8'd0;
      end else begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      err_p0 <= in_lane && !dmem_ready && lane_to;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign lane_to        = 1'b0;
  assign err            = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      st_p0     <= 1'b0;
      en1_p0    <= 1'b0;
      addr0_p0  <= 32'd0;
      addr1_p0  <= 32'd0;
      sd0_p0    <= 32'd0;
      sd1_p0    <= 32'd0;
      eew_p0    <= 2'd0;
      loaddata0 <= 32'd0;
      loaddata1 <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (load || store) begin
            st_p0    <= store;
            en1_p0   <= lane_en1;
            addr0_p0 <= aluresult0;
            addr1_p0 <= aluresult1;
            sd0_p0   <= storedata0;
            sd1_p0   <= storedata1;
            eew_p0   <= eew;
            if (lane_en0) begin
              state <= LANE0;
            end else if (lane_en1) begin
              state <= LANE1;
            end else begin
              state <= DONE;
            end
          end
        end
        LANE0: begin
          if (dmem_ready) begin
            if (!st_p0) begin
              loaddata0 <= rd_ext;
            end
            state <= en1_p0 ? LANE1 : DONE;
          end else if (lane_to) begin
            state <= DONE;
          end
        end
        LANE1: begin
          if (dmem_ready) begin
            if (!st_p0) begin
              loaddata1 <= rd_ext;
            end
            state <= DONE;
          end else if (lane_to) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/rv32v_lane_mem_sequencer.md
# rv32v_lane_mem_sequencer

Serializes the two-lane vector memory-stage access (lane 0 / lane 1 element addresses, store data, EEW) onto the single scalar data-memory port. It sits in the vector memory stage between the execute/memory pipeline latch and the dcache/bus port. It stalls the vector pipeline while elements are in flight and returns aligned, zero-extended load data per lane.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64, wait cycles per element before abort (used only with RV32V_MEM_TIMEOUT_EN)

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- load, store  in  1  memory op request from the execute/memory latch; store wins if both are high
- lane_en0, lane_en1  in  1  lane holds a valid element (driven from wen0/wen1)
- aluresult0, aluresult1  in  32  element byte addresses
- storedata0, storedata1  in  32  element store data, right-justified
- eew  in  2  element width: 0 = 8-bit, 1 = 16-bit, 2 = 32-bit; 3 is treated as 32-bit
- dmem_ren, dmem_wen  out  1  memory request strobes
- dmem_addr  out  32  word address {addr[31:2],2'b00}
- dmem_wdata  out  32  lane-shifted store data
- dmem_byte_en  out  4  byte enables
- dmem_rdata  in  32  read data, valid when dmem_ready is high
- dmem_ready  in  1  access completes this cycle
- loaddata0, loaddata1  out  32  extracted, zero-extended load results
- stall  out  1  hold the vector pipeline
- done  out  1  one-cycle pulse: operation complete
- err  out  1  one-cycle pulse with done on timeout abort

## Operation
- FSM states: IDLE, LANE0, LANE1, DONE.
- IDLE:
  - if (load|store), latch op, enables, addresses, store data and eew.
  - Next state: LANE0 if lane_en0, else LANE1 if lane_en1, else DONE.
  - No memory traffic when neither lane is enabled.
- LANEx drives the request from the latched lane-x fields.
  - On dmem_ready with load: write the extracted data to loaddatax.
  - Then go to LANE1 (from LANE0, if lane_en1 is latched) or to DONE.
  - Without dmem_ready: stay in LANEx and hold all request outputs stable.
- DONE: done = 1, then go to IDLE. A new request is accepted in IDLE on the following cycle.
- Byte enables:
  - 8-bit: 4'b0001 << a[1:0]
  - 16-bit: 4'b0011 << {a[1],1'b0}
  - 32-bit: 4'b1111
  - Misaligned low bits are ignored (address aligned down).
- dmem_wdata: store data shifted left by 8×a[1:0] (8-bit) or 16×a[1] (16-bit); unshifted for 32-bit.
- Load extract: shift dmem_rdata right by the same amount, mask to eew, zero-extend.
- stall = (state is LANE0 or LANE1) or (state is IDLE and (load|store)). stall is 0 in DONE.
- loaddata0 and loaddata1 hold their values until overwritten by a later load. Lanes not accessed keep their old value.

## Timing
- Reset values: state IDLE; all outputs 0; loaddata0/1 = 0; latched fields 0.
- Reset mid-operation aborts immediately. The request strobes drop asynchronously and no done pulse is produced.
- Latency with dmem_ready always high:
  - accept cycle T (IDLE, stall = 1)
  - LANE0 at T+1, LANE1 at T+2
  - DONE at T+3 (done = 1, stall = 0)
- Single lane: done at T+2. No lanes enabled: done at T+1.
- Each wait cycle on dmem_ready adds one cycle. dmem_ren/dmem_wen are never both high.
- dmem_* outputs are registered-state decodes: combinational from state plus latched fields only, never from inputs.

## Configuration
- RV32V_MEM_TIMEOUT_EN defined:
  - An 8-bit wait counter clears on each LANEx entry and increments each cycle without dmem_ready.
  - When it reaches TIMEOUT_CYCLES−1 without ready, the FSM goes to DONE, skips remaining lanes and leaves their loaddata unchanged.
  - err pulses together with done.
- Undefined: no counter, LANEx waits indefinitely, err tied 0.

## Test plan
- Load, both lanes, eew = 2, addrs 0x100/0x104, ready always high, rdata 0xDEADBEEF then 0x12345678 → loaddata0 = 0xDEADBEEF, loaddata1 = 0x12345678; done at T+3; stall high T..T+2.
- Store, eew = 0, lane0 only, addr 0x203, data 0xAB → dmem_addr 0x200, byte_en 4'b1000, wdata 0xAB000000, one request; done at T+2.
- Load, eew = 1, addr 0x302, rdata 0xBEEF1234 → loaddata0 = 0x0000BEEF; ready held low 3 cycles → addr/ren stable throughout; done 3 cycles later.
- load = store = 1 → only dmem_wen asserted; no loaddata change.
- Neither lane enabled with load → no dmem strobe; done at T+1.
- nRST pulsed low while in LANE1 → outputs 0 immediately, state IDLE, no done.
- With RV32V_MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 4, ready never high → done and err pulse together; lane1 never requested.
